// File: rtl/btn_pkg.sv
// btn_pkg: state encoding and shared timing defaults for the button chain
package btn_pkg;

    typedef enum logic [1:0] {
        REPOSO     = 2'd0,
        PRESIONADO = 2'd1,
        LARGO      = 2'd2
    } estado_t;

    // Thresholds expressed in 50 MHz clock cycles, shared with btnRT
    localparam int LARGO_CICLOS_DEF   = 25000;
    localparam int REPETIR_CICLOS_DEF = 5000;
    localparam int CNT_W_DEF          = 16;

endpackage

// File: rtl/btn_evento.sv
// btn_evento: classifies conditioned button presses into short/long/repeat pulses
module btn_evento
    import btn_pkg::*;
#(
    parameter int LARGO_CICLOS   = LARGO_CICLOS_DEF,
    parameter int REPETIR_CICLOS = REPETIR_CICLOS_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic boton_in,
    output logic pulso_corto,
    output logic pulso_largo,
    output logic pulso_repetir,
    output logic presionado
);

    localparam logic [CNT_W-1:0] LARGO_FIN   = CNT_W'(LARGO_CICLOS - 1);
    localparam logic [CNT_W-1:0] REPETIR_FIN = CNT_W'(REPETIR_CICLOS - 1);
    localparam bit               REPETIR_ON  = REPETIR_CICLOS != 0;

    estado_t          estado_q;
    logic [CNT_W-1:0] cnt_q;
    logic             corto_q, largo_q, repetir_q;

    // Press FSM: counts consecutive high samples, release is evaluated before thresholds
    always_ff @(posedge clk) begin
        if (!rst) begin
            estado_q  <= REPOSO;
            cnt_q     <= '0;
            corto_q   <= 1'b0;
            largo_q   <= 1'b0;
            repetir_q <= 1'b0;
        end else begin
            corto_q   <= 1'b0;
            largo_q   <= 1'b0;
            repetir_q <= 1'b0;
            case (estado_q)
                REPOSO: begin
                    estado_q <= boton_in ? PRESIONADO : REPOSO;
                    cnt_q    <= boton_in ? CNT_W'(1) : '0;
                end
                PRESIONADO: begin
                    if (!boton_in) begin
                        corto_q  <= 1'b1;
                        estado_q <= REPOSO;
                        cnt_q    <= '0;
                    end else if (cnt_q == LARGO_FIN) begin
                        largo_q  <= 1'b1;
                        estado_q <= LARGO;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                LARGO: begin
                    if (!boton_in) begin
                        estado_q <= REPOSO;
                        cnt_q    <= '0;
                    end else if (REPETIR_ON && cnt_q == REPETIR_FIN) begin
                        repetir_q <= 1'b1;
                        cnt_q     <= '0;
                    end else if (REPETIR_ON) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    estado_q <= REPOSO;
                    cnt_q    <= '0;
                end
            endcase
        end
    end

    assign pulso_corto   = corto_q;
    assign pulso_largo   = largo_q;
    assign pulso_repetir = repetir_q;
    assign presionado    = estado_q != REPOSO;

endmodule

// File: tb/tb_btn_evento.sv
// tb_btn_evento: directed checks of press classification on scaled thresholds
module tb_btn_evento;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic boton_in = 1'b0;
    logic pc_a, pl_a, pr_a, pres_a;
    logic pc_b, pl_b, pr_b, pres_b;

    int n_chk = 0, n_fail = 0;
    int n_c, n_l, n_r, n_l_b, n_r_b, n_excl;

    always #10 clk = ~clk;

    // Scaled: long press at 10 high samples, repeat every 4
    btn_evento #(.LARGO_CICLOS(10), .REPETIR_CICLOS(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .boton_in(boton_in),
        .pulso_corto(pc_a), .pulso_largo(pl_a), .pulso_repetir(pr_a), .presionado(pres_a)
    );

    // Same long threshold, repeat disabled
    btn_evento #(.LARGO_CICLOS(10), .REPETIR_CICLOS(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .boton_in(boton_in),
        .pulso_corto(pc_b), .pulso_largo(pl_b), .pulso_repetir(pr_b), .presionado(pres_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_c = 0; n_l = 0; n_r = 0; n_l_b = 0; n_r_b = 0;
    endtask

    // One sample: drive, clock, then observe just after the edge
    task automatic tick(input logic b);
        boton_in = b;
        @(posedge clk);
        #1;
        n_c   += int'(pc_a);
        n_l   += int'(pl_a);
        n_r   += int'(pr_a);
        n_l_b += int'(pl_b);
        n_r_b += int'(pr_b);
        if (int'(pc_a) + int'(pl_a) + int'(pr_a) > 1) n_excl++;
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) tick(b);
    endtask

    initial begin
        n_excl = 0;
        clr();
        // Reset held with button high
        rst = 1'b0;
        hold(1'b1, 10);
        chk("rst_outs", int'({pc_a, pl_a, pr_a}), 0);
        chk("rst_pres", int'(pres_a), 0);
        chk("rst_cnt", n_c + n_l + n_r, 0);
        rst = 1'b1;
        tick(1'b1);
        chk("post_rst_pres", int'(pres_a), 1);
        tick(1'b0);
        chk("post_rst_corto", int'(pc_a), 1);
        chk("post_rst_pres_fall", int'(pres_a), 0);
        tick(1'b0);
        chk("corto_width", int'(pc_a), 0);
        // Short press of 5 samples
        clr();
        hold(1'b1, 5);
        chk("short_none_yet", n_c + n_l + n_r, 0);
        tick(1'b0);
        chk("short_pulse", int'(pc_a), 1);
        tick(1'b0);
        chk("short_count", n_c, 1);
        chk("short_no_largo", n_l, 0);
        // One below threshold
        clr();
        hold(1'b1, 9);
        hold(1'b0, 2);
        chk("l_minus1_corto", n_c, 1);
        chk("l_minus1_largo", n_l, 0);
        // Exactly at threshold
        clr();
        hold(1'b1, 9);
        chk("l_before", int'(pl_a), 0);
        tick(1'b1);
        chk("l_exact_pulse", int'(pl_a), 1);
        chk("l_exact_b_pulse", int'(pl_b), 1);
        hold(1'b0, 3);
        chk("l_release_corto", n_c, 0);
        chk("l_release_largo", n_l, 1);
        chk("l_release_pres", int'(pres_a), 0);
        // Long hold with repeats at 14 and 18, released where 22 would fire
        clr();
        hold(1'b1, 10);
        chk("rep_largo", int'(pl_a), 1);
        hold(1'b1, 3);
        chk("rep1_early", n_r, 0);
        tick(1'b1);
        chk("rep1_pulse", int'(pr_a), 1);
        hold(1'b1, 4);
        chk("rep2_pulse", int'(pr_a), 1);
        chk("rep2_count", n_r, 2);
        hold(1'b1, 3);
        tick(1'b0);
        chk("rep_release_wins", int'(pr_a), 0);
        chk("rep_release_pres", int'(pres_a), 0);
        tick(1'b0);
        chk("rep_total", n_r, 2);
        chk("rep_no_corto", n_c, 0);
        chk("norep_largo", n_l_b, 1);
        chk("norep_repetir", n_r_b, 0);
        // Repeat disabled across a long hold
        clr();
        hold(1'b1, 40);
        chk("norep_long_pres", int'(pres_b), 1);
        hold(1'b0, 2);
        chk("norep_long_largo", n_l_b, 1);
        chk("norep_long_rep", n_r_b, 0);
        // Reset in the middle of a press
        clr();
        hold(1'b1, 7);
        rst = 1'b0;
        tick(1'b1);
        chk("midrst_pres", int'(pres_a), 0);
        tick(1'b0);
        rst = 1'b1;
        hold(1'b0, 3);
        chk("midrst_no_pulse", n_c + n_l + n_r, 0);
        // Counter restarts from zero after that reset
        hold(1'b1, 9);
        chk("midrst_restart_none", n_l, 0);
        tick(1'b1);
        chk("midrst_restart_largo", int'(pl_a), 1);
        hold(1'b0, 2);
        chk("exclusive", n_excl, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
